// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - iterative 32-bit restoring divide controller for the E stage
//
// Runs DIV/DIVU as 32 radix-2 restoring iterations, holding the pipeline with
// a stall request until {HI, LO} is ready for the write in M.
//
// Ports:
//   clk          pipeline clock, rising edge
//   rst          asynchronous active-high reset
//   start_i      DIV/DIVU valid in E (held while the instruction sits in E)
//   signed_i     1 = DIV (two's complement), 0 = DIVU
//   a_i, b_i     dividend / divisor, sampled only on the accepting cycle
//   annul_i      flush / exception abort, kills any operation in flight
//   stall_div_o  stall request to the hazard unit
//   ready_o      one-cycle pulse, result_o valid for HI/LO write
//   result_o     {HI = remainder, LO = quotient}, registered

module div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        annul_i,
    output logic        stall_div_o,
    output logic        ready_o,
    output logic [63:0] result_o
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] quot_q, quot_d;
    logic [32:0] div_q, div_d;
    logic        neg_quot_q, neg_quot_d;
    logic        neg_rem_q, neg_rem_d;
    logic [63:0] result_q, result_d;

    logic [31:0] a_mag, b_mag;
    logic [33:0] rem_sh, trial;
    logic [32:0] rem_nx;
    logic [31:0] quot_nx;
    logic [31:0] fin_hi, fin_lo;

    // Magnitude of 0x8000_0000 wraps to itself, which is correct when the
    // value is then treated as unsigned in the 33-bit datapath.
    assign a_mag = (signed_i && a_i[31]) ? (32'd0 - a_i) : a_i;
    assign b_mag = (signed_i && b_i[31]) ? (32'd0 - b_i) : b_i;

    // One restoring step: shift {rem, quot} left, try subtracting the divisor.
    // rem_q[32] is always zero between steps; it is carried so the shifted
    // remainder can exceed 32 bits when the divisor is close to 2^32.
    assign rem_sh  = {rem_q, quot_q[31]};
    assign trial   = rem_sh - {1'b0, div_q};
    assign rem_nx  = trial[33] ? rem_sh[32:0] : trial[32:0];
    assign quot_nx = {quot_q[30:0], ~trial[33]};

    // Sign fix-up is applied to the final step's outputs so result_o can be
    // written on the same edge that enters DONE.
    assign fin_lo = neg_quot_q ? (32'd0 - quot_nx) : quot_nx;
    assign fin_hi = neg_rem_q ? (32'd0 - rem_nx[31:0]) : rem_nx[31:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            div_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            div_q      <= div_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quot_d      = quot_q;
        div_d       = div_q;
        neg_quot_d  = neg_quot_q;
        neg_rem_d   = neg_rem_q;
        result_d    = result_q;
        stall_div_o = 1'b0;
        ready_o     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i && !annul_i) begin
                    stall_div_o = 1'b1;
                    if (b_i == 32'd0) begin
                        state_d  = S_DONE;
                        result_d = {a_i, 32'hFFFF_FFFF};
                    end else begin
                        state_d    = S_BUSY;
                        cnt_d      = 5'd0;
                        rem_d      = '0;
                        quot_d     = a_mag;
                        div_d      = {1'b0, b_mag};
                        neg_quot_d = signed_i & (a_i[31] ^ b_i[31]);
                        neg_rem_d  = signed_i & a_i[31];
                    end
                end
            end
            S_BUSY: begin
                if (annul_i) begin
                    state_d = S_IDLE;
                end else begin
                    stall_div_o = 1'b1;
                    rem_d       = rem_nx;
                    quot_d      = quot_nx;
                    cnt_d       = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d  = S_DONE;
                        result_d = {fin_hi, fin_lo};
                    end
                end
            end
            S_DONE: begin
                // start_i is ignored here; the instruction leaves E this cycle.
                state_d = S_IDLE;
                ready_o = ~annul_i;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign result_o = result_q;

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - directed self-checking bench for div_ctrl

module tb_div_ctrl;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        annul_i;
    logic        stall_div_o;
    logic        ready_o;
    logic [63:0] result_o;

    int total;
    int bad;

    div_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .signed_i    (signed_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .annul_i     (annul_i),
        .stall_div_o (stall_div_o),
        .ready_o     (ready_o),
        .result_o    (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one divide with start_i held until the ready cycle, then drop it.
    task automatic do_div(input string tag, input logic sg, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int lat);
        int k;
        int first;
        int nstall;
        k      = 0;
        first  = -1;
        nstall = 0;
        @(posedge clk); #1;
        start_i  = 1'b1;
        signed_i = sg;
        a_i      = a;
        b_i      = b;
        while (first < 0 && k <= lat + 5) begin
            @(negedge clk);
            if (stall_div_o) nstall++;
            if (ready_o) begin
                first = k;
                check({tag, "_result"}, result_o, exp);
            end else begin
                k++;
            end
        end
        check({tag, "_latency"}, 64'(first), 64'(lat));
        check({tag, "_stall_cycles"}, 64'(nstall), 64'(lat));
        @(posedge clk); #1;
        start_i = 1'b0;
        @(negedge clk);
        check({tag, "_ready_after"}, {63'd0, ready_o}, 64'd0);
    endtask

    initial begin
        int seen;
        int t1, t2;
        logic [63:0] r1, r2;
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        start_i  = 1'b0;
        signed_i = 1'b0;
        a_i      = '0;
        b_i      = '0;
        annul_i  = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_stall", {63'd0, stall_div_o}, 64'd0);
        check("rst_ready", {63'd0, ready_o}, 64'd0);
        check("rst_result", result_o, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_div("u100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
        do_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
        do_div("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33);
        do_div("dbz", 1'b0, 32'h1234_5678, 32'd0, {32'h1234_5678, 32'hFFFF_FFFF}, 1);

        // Annul during BUSY at cycle 10.
        @(posedge clk); #1;
        start_i  = 1'b1;
        signed_i = 1'b0;
        a_i      = 32'hFFFF_FFFF;
        b_i      = 32'd3;
        repeat (10) @(posedge clk);
        #1;
        annul_i = 1'b1;
        #1;
        check("annul_stall_low", {63'd0, stall_div_o}, 64'd0);
        @(posedge clk); #1;
        annul_i = 1'b0;
        start_i = 1'b0;
        seen = 0;
        for (int k = 11; k <= 40; k++) begin
            @(negedge clk);
            if (ready_o) seen++;
        end
        check("annul_no_ready", 64'(seen), 64'd0);
        check("annul_result_held", result_o, {32'h1234_5678, 32'hFFFF_FFFF});
        do_div("u9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

        // Asynchronous reset mid-divide.
        @(posedge clk); #1;
        start_i  = 1'b1;
        signed_i = 1'b0;
        a_i      = 32'h1000;
        b_i      = 32'd7;
        repeat (5) @(posedge clk);
        #3;
        rst     = 1'b1;
        start_i = 1'b0;
        #1;
        check("arst_stall", {63'd0, stall_div_o}, 64'd0);
        check("arst_ready", {63'd0, ready_o}, 64'd0);
        check("arst_result", result_o, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        do_div("u16_4", 1'b0, 32'h10, 32'h4, {32'd0, 32'd4}, 33);

        // Back-to-back divides with start_i held throughout.
        t1 = -1;
        t2 = -1;
        r1 = '0;
        r2 = '0;
        @(posedge clk); #1;
        start_i  = 1'b1;
        signed_i = 1'b0;
        a_i      = 32'd50;
        b_i      = 32'd5;
        for (int k = 0; k < 90 && t2 < 0; k++) begin
            @(negedge clk);
            if (ready_o) begin
                if (t1 < 0) begin
                    t1  = k;
                    r1  = result_o;
                    a_i = 32'd51;
                end else begin
                    t2 = k;
                    r2 = result_o;
                end
            end
        end
        @(posedge clk); #1;
        start_i = 1'b0;
        check("b2b_first_latency", 64'(t1), 64'd33);
        check("b2b_spacing", 64'(t2 - t1), 64'd34);
        check("b2b_result1", r1, {32'd0, 32'd10});
        check("b2b_result2", r2, {32'd1, 32'd10});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
